// File: rtl/alu_issue_stage_pkg.sv
// Shared width definitions for the ALU operand-issue stage and its register file.
package alu_issue_stage_pkg;

  localparam int DATA_INDEX_LIMIT     = 31;
  localparam int ALU_OPRN_INDEX_LIMIT = 5;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  localparam int REG_COUNT            = 32;

endpackage

// File: rtl/alu_issue_stage_register_file.sv
// General register file: two combinational read ports with write-through bypass,
// one synchronous write port, R0 hardwired to zero.
module register_file
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_INDEX_LIMIT + 1,
  parameter int REG_ADDR_WIDTH = REG_ADDR_INDEX_LIMIT + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic [DATA_WIDTH-1:0]     rdata2,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // Same-cycle write to a source index is forwarded so the reader sees the new value.
  always_comb begin
    rdata1 = regs_reg[raddr1];
    rdata2 = regs_reg[raddr2];
    if (we && (waddr == raddr1)) rdata1 = wdata;
    if (we && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding the ALU: register file read, busy scoreboard for RAW
// hazards, and a registered valid/ready output stage.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_INDEX_LIMIT + 1,
  parameter int REG_ADDR_WIDTH = REG_ADDR_INDEX_LIMIT + 1,
  parameter int OPRN_WIDTH     = ALU_OPRN_INDEX_LIMIT + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_use_imm,
  input  logic [OPRN_WIDTH-1:0]     in_oprn,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [OPRN_WIDTH-1:0]     oprn,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rdata1, rdata2;
  logic [NREGS-1:0]      busy_reg, busy_next, busy_eff, clear_mask, set_mask;
  logic                  hazard, issue;

  logic                  ex_valid_reg;
  logic [DATA_WIDTH-1:0] op1_reg, op2_reg;
  logic [OPRN_WIDTH-1:0] oprn_reg;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_reg;

  register_file #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .raddr1(in_rs1),
    .raddr2(in_rs2),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  // Per-register decode of this cycle's write-back clear and issue set.
  assign clear_mask[0] = 1'b0;
  assign set_mask[0]   = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_masks
      assign clear_mask[gi] = wb_en && (wb_addr == REG_ADDR_WIDTH'(gi));
      assign set_mask[gi]   = issue && (in_rd == REG_ADDR_WIDTH'(gi));
    end
  endgenerate

  // A producer writing back this cycle no longer blocks its consumer.
  assign busy_eff  = busy_reg & ~clear_mask;
  assign busy_next = busy_eff | set_mask;

  assign hazard   = busy_eff[in_rs1] || (!in_use_imm && busy_eff[in_rs2]);
  assign in_ready = (!ex_valid_reg || ex_ready) && !hazard;
  assign issue    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      oprn_reg     <= '0;
      ex_rd_reg    <= '0;
    end else if (issue) begin
      ex_valid_reg <= 1'b1;
      op1_reg      <= rdata1;
      op2_reg      <= in_use_imm ? in_imm : rdata2;
      oprn_reg     <= in_oprn;
      ex_rd_reg    <= in_rd;
    end else if (ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  assign ex_valid = ex_valid_reg;
  assign op1      = op1_reg;
  assign op2      = op2_reg;
  assign oprn     = oprn_reg;
  assign ex_rd    = ex_rd_reg;

endmodule
